// File: rtl/audipus_audio_pkg.sv
// Shared audio-path constants and sample types.
//   SAMPLE_W / SLOT_W / BITS_PER_FRAME : I2S frame geometry (24-bit data, 32-bit slots, 64 bclk)
//   BCLK_DIV_*                         : clk cycles per bclk half-period at 49.152 MHz mclk
package audipus_audio_pkg;

  localparam int unsigned SAMPLE_W       = 24;
  localparam int unsigned SLOT_W         = 32;
  localparam int unsigned BITS_PER_FRAME = 64;
  localparam int unsigned BIT_CNT_W      = $clog2(BITS_PER_FRAME);

  localparam int unsigned BCLK_DIV_48K  = 8;
  localparam int unsigned BCLK_DIV_96K  = 4;
  localparam int unsigned BCLK_DIV_192K = 2;

  typedef logic [SAMPLE_W-1:0] sample_t;

  // One left/right sample pair as held or transmitted together.
  typedef struct packed {
    sample_t left;
    sample_t right;
  } sample_pair_t;

endpackage

// File: rtl/i2s_transmitter_if.sv
// Sample-side strobes and I2S-side outputs of the transmitter.
//   master : sample source / observer (drives strobes, data, mute)
//   slave  : i2s_transmitter (drives the I2S lines and status pulses)
interface i2s_transmitter_if;
  import audipus_audio_pkg::*;

  logic    l_valid;
  logic    r_valid;
  sample_t l_data;
  sample_t r_data;
  logic    mute;

  logic    i2s_bclk;
  logic    i2s_lrclk;
  logic    i2s_sdata;
  logic    frame_strobe;
  logic    underrun;
  logic    overrun;

  modport master (
    output l_valid, r_valid, l_data, r_data, mute,
    input  i2s_bclk, i2s_lrclk, i2s_sdata, frame_strobe, underrun, overrun
  );

  modport slave (
    input  l_valid, r_valid, l_data, r_data, mute,
    output i2s_bclk, i2s_lrclk, i2s_sdata, frame_strobe, underrun, overrun
  );

endinterface

// File: rtl/i2s_transmitter_clk_gen.sv
// Bit-clock generator: divides clk into bclk and counts bclk falling edges per frame.
//   clk, reset   : master clock, synchronous active-high reset
//   bclk         : registered bit clock
//   bit_cnt      : registered bclk position within the 64-bit frame
//   fall_tick_c  : this cycle's edge drives bclk 1->0 (bit_cnt advances)
//   frame_tick_c : fall_tick_c with bit_cnt wrapping 63->0
module i2s_clk_gen
  import audipus_audio_pkg::*;
#(
  parameter int unsigned BCLK_DIV = BCLK_DIV_48K
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 bclk,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic                 fall_tick_c,
  output logic                 frame_tick_c
);

  localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             div_wrap_c;

  // Toggle decode for the current cycle.
  always_comb begin
    div_wrap_c   = (div_cnt == DIV_W'(BCLK_DIV - 1));
    fall_tick_c  = div_wrap_c && bclk;
    frame_tick_c = fall_tick_c && (bit_cnt == BIT_CNT_W'(BITS_PER_FRAME - 1));
  end

  // Divider, bclk and frame bit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= '0;
    end else begin
      if (div_wrap_c) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (fall_tick_c) begin
        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/i2s_transmitter.sv
// Philips I2S transmitter: buffers one L/R sample pair and serializes it MSB-first
// with a one-bclk delay in 32-bit slots, 64 bclk per frame.
//   clk, reset : master clock, synchronous active-high reset
//   bus.slave  : l/r_valid, l/r_data, mute in; i2s_bclk, i2s_lrclk, i2s_sdata,
//                frame_strobe, underrun, overrun out (all registered)
module i2s_transmitter
  import audipus_audio_pkg::*;
#(
  parameter int unsigned BCLK_DIV  = BCLK_DIV_48K,
  parameter int unsigned DATA_BITS = SAMPLE_W,
  parameter int unsigned SLOT_BITS = SLOT_W
) (
  input  logic             clk,
  input  logic             reset,
  i2s_transmitter_if.slave bus
);

  localparam int unsigned POS_W = $clog2(SLOT_BITS);

  logic                 bclk;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 fall_tick_c;
  logic                 frame_tick_c;

  sample_pair_t hold;
  sample_pair_t active;
  logic         l_fresh;
  logic         r_fresh;

  logic lrclk_q;
  logic sdata_q;
  logic frame_strobe_q;
  logic underrun_q;
  logic overrun_q;

  logic [BIT_CNT_W-1:0] bit_cnt_next_c;
  logic [POS_W-1:0]     slot_pos_c;
  logic [POS_W-1:0]     bit_idx_c;
  sample_t              slot_word_c;
  logic                 sdata_next_c;
  logic                 overrun_c;

  i2s_clk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_clk_gen (
    .clk          (clk),
    .reset        (reset),
    .bclk         (bclk),
    .bit_cnt      (bit_cnt),
    .fall_tick_c  (fall_tick_c),
    .frame_tick_c (frame_tick_c)
  );

  // Serial bit for the slot position bit_cnt is about to enter; MSB lands one bclk into the slot.
  always_comb begin
    bit_cnt_next_c = bit_cnt + BIT_CNT_W'(1);
    slot_pos_c     = bit_cnt_next_c[POS_W-1:0];
    slot_word_c    = bit_cnt_next_c[POS_W] ? active.right : active.left;
    bit_idx_c      = POS_W'(DATA_BITS) - slot_pos_c;
    sdata_next_c   = 1'b0;
    if ((slot_pos_c != '0) && (slot_pos_c <= POS_W'(DATA_BITS))) begin
      sdata_next_c = slot_word_c[bit_idx_c];
    end
    // A strobe on the frame-start cycle refills a just-consumed slot, so it is not an overrun.
    overrun_c = ((bus.l_valid && l_fresh) || (bus.r_valid && r_fresh)) && !frame_tick_c;
  end

  // Capture, frame-start transfer and serializer output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold           <= '0;
      active         <= '0;
      l_fresh        <= 1'b0;
      r_fresh        <= 1'b0;
      lrclk_q        <= 1'b0;
      sdata_q        <= 1'b0;
      frame_strobe_q <= 1'b0;
      underrun_q     <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      frame_strobe_q <= frame_tick_c;
      underrun_q     <= frame_tick_c && !(l_fresh && r_fresh);
      overrun_q      <= overrun_c;

      if (fall_tick_c) begin
        lrclk_q <= bit_cnt_next_c[POS_W];
        sdata_q <= sdata_next_c;
      end

      // Both channels move together so L/R can never slip by a slot.
      if (frame_tick_c) begin
        active <= bus.mute ? '0 : hold;
      end

      if (bus.l_valid) begin
        hold.left <= bus.l_data;
        l_fresh   <= 1'b1;
      end else if (frame_tick_c) begin
        l_fresh   <= 1'b0;
      end

      if (bus.r_valid) begin
        hold.right <= bus.r_data;
        r_fresh    <= 1'b1;
      end else if (frame_tick_c) begin
        r_fresh    <= 1'b0;
      end
    end
  end

  assign bus.i2s_bclk     = bclk;
  assign bus.i2s_lrclk    = lrclk_q;
  assign bus.i2s_sdata    = sdata_q;
  assign bus.frame_strobe = frame_strobe_q;
  assign bus.underrun     = underrun_q;
  assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Self-checking bench for i2s_transmitter: directed scenarios plus random strobes,
// every clk compared against a frame-level reference model.
module tb_i2s_transmitter;
  import audipus_audio_pkg::*;

  localparam int DIV        = int'(BCLK_DIV_192K);
  localparam int FRAME_CLK  = 2 * DIV * 64;
  localparam int MAX_FRAMES = 128;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  i2s_transmitter_if bus();

  i2s_transmitter #(
    .BCLK_DIV (DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int evaluated = 0;
  int failures  = 0;

  // Reference model state: n = clk edges since reset release.
  int          n = 0;
  logic [23:0] m_hold_l = '0;
  logic [23:0] m_hold_r = '0;
  bit          m_fl = 0;
  bit          m_fr = 0;
  bit          exp_ov = 0;
  logic [23:0] wl [MAX_FRAMES];
  logic [23:0] wr [MAX_FRAMES];
  bit          und [MAX_FRAMES];

  int cnt_fs    = 0;
  int cnt_under = 0;
  int cnt_over  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    evaluated++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s at n=%0d: observed %0h expected %0h", tag, n, got, exp);
    end
  endtask

  // Apply the spec rules for the edge just taken, using the inputs presented to it.
  task automatic model_edge();
    int f;
    if (reset) begin
      n = 0;
      m_hold_l = '0;
      m_hold_r = '0;
      m_fl = 0;
      m_fr = 0;
      exp_ov = 0;
      wl[0] = '0;
      wr[0] = '0;
      und[0] = 0;
    end else begin
      n++;
      exp_ov = 0;
      if (n % FRAME_CLK == 0) begin
        f = n / FRAME_CLK;
        if (f < MAX_FRAMES) begin
          wl[f]  = bus.mute ? 24'h0 : m_hold_l;
          wr[f]  = bus.mute ? 24'h0 : m_hold_r;
          und[f] = !(m_fl && m_fr);
        end
        m_fl = 0;
        m_fr = 0;
      end
      if (bus.l_valid) begin
        if (m_fl) exp_ov = 1;
        m_hold_l = bus.l_data;
        m_fl = 1;
      end
      if (bus.r_valid) begin
        if (m_fr) exp_ov = 1;
        m_hold_r = bus.r_data;
        m_fr = 1;
      end
    end
  endtask

  // Expected waveform at edge count n, from plain arithmetic on the frame geometry.
  task automatic compare_outputs();
    int falls, bitn, frame, p, ch, e_sd;
    bit e_fs;
    logic [23:0] w;
    falls = n / (2 * DIV);
    bitn  = falls % 64;
    frame = n / FRAME_CLK;
    p     = bitn % 32;
    ch    = bitn / 32;
    if (frame >= MAX_FRAMES) begin
      check("frame_budget", 32'(frame), 32'(MAX_FRAMES - 1));
      frame = MAX_FRAMES - 1;
    end
    w     = (ch != 0) ? wr[frame] : wl[frame];
    e_sd  = (p >= 1 && p <= 24) ? int'(w[5'(24 - p)]) : 0;
    e_fs  = (n > 0) && (n % FRAME_CLK == 0);
    check("bclk", 32'(bus.i2s_bclk), 32'((n / DIV) % 2));
    check("lrclk", 32'(bus.i2s_lrclk), 32'(ch));
    check("sdata", 32'(bus.i2s_sdata), 32'(e_sd));
    check("frame_strobe", 32'(bus.frame_strobe), 32'(e_fs));
    check("underrun", 32'(bus.underrun), 32'(e_fs && und[frame]));
    check("overrun", 32'(bus.overrun), 32'(exp_ov));
    if (bus.frame_strobe === 1'b1) cnt_fs++;
    if (bus.underrun === 1'b1) cnt_under++;
    if (bus.overrun === 1'b1) cnt_over++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    compare_outputs();
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  // Step until the edge just taken was a frame start.
  task automatic run_to_frame_start();
    for (int i = 0; i < FRAME_CLK; i++) begin
      step();
      if (n % FRAME_CLK == 0) break;
    end
  endtask

  // Step until the next edge will be a frame start.
  task automatic run_until_before_frame();
    for (int i = 0; i < FRAME_CLK && ((n + 1) % FRAME_CLK != 0); i++) step();
  endtask

  task automatic strobe(input bit lv, input bit rv, input logic [23:0] ld, input logic [23:0] rd);
    bus.l_valid = lv;
    bus.r_valid = rv;
    bus.l_data  = ld;
    bus.r_data  = rd;
    step();
    bus.l_valid = 1'b0;
    bus.r_valid = 1'b0;
  endtask

  task automatic clear_counts();
    cnt_fs = 0;
    cnt_under = 0;
    cnt_over = 0;
  endtask

  initial begin
    bus.l_valid = 1'b0;
    bus.r_valid = 1'b0;
    bus.l_data  = '0;
    bus.r_data  = '0;
    bus.mute    = 1'b0;

    // Reset state.
    reset = 1'b1;
    run(3);
    reset = 1'b0;

    // Idle: zeros on sdata, underrun every frame.
    clear_counts();
    run(3 * FRAME_CLK);
    check("idle_frames", 32'(cnt_fs), 32'd3);
    check("idle_underruns", 32'(cnt_under), 32'd3);
    check("idle_overruns", 32'(cnt_over), 32'd0);

    // One fresh pair per frame, mid-frame.
    clear_counts();
    repeat (3) begin
      run(100);
      strobe(1, 1, 24'hA5A5A5, 24'h5A5A5A);
      run(FRAME_CLK - 101);
    end
    check("steady_frames", 32'(cnt_fs), 32'd3);
    check("steady_underruns", 32'(cnt_under), 32'd0);
    check("steady_overruns", 32'(cnt_over), 32'd0);

    // Two left strobes in one frame: newest wins, one overrun.
    clear_counts();
    run(50);
    strobe(1, 1, 24'h123456, 24'h0F0F0F);
    run(50);
    strobe(1, 0, 24'h7FFFFF, 24'h000000);
    run_to_frame_start();
    check("double_overruns", 32'(cnt_over), 32'd1);
    check("double_underruns", 32'(cnt_under), 32'd0);

    // Strobes exactly on the frame-start edge go to the following frame.
    clear_counts();
    run(60);
    strobe(1, 1, 24'h111111, 24'h222222);
    run_until_before_frame();
    strobe(1, 1, 24'h800000, 24'h800000);
    run_to_frame_start();
    check("edge_frames", 32'(cnt_fs), 32'd2);
    check("edge_underruns", 32'(cnt_under), 32'd0);
    check("edge_overruns", 32'(cnt_over), 32'd0);

    // Mute zeroes the next frame; unmute repeats the held pair with an underrun.
    clear_counts();
    run(60);
    strobe(1, 1, 24'h7FFF00, 24'h7FFF00);
    bus.mute = 1'b1;
    run_to_frame_start();
    check("mute_underruns", 32'(cnt_under), 32'd0);
    run(100);
    bus.mute = 1'b0;
    run_to_frame_start();
    check("unmute_underruns", 32'(cnt_under), 32'd1);
    check("mute_overruns", 32'(cnt_over), 32'd0);

    // Random strobes, data and mute.
    for (int i = 0; i < 6 * FRAME_CLK; i++) begin
      bus.l_valid = ($urandom_range(0, 199) == 0);
      bus.r_valid = ($urandom_range(0, 199) == 0);
      bus.l_data  = 24'($urandom);
      bus.r_data  = 24'($urandom);
      if ($urandom_range(0, 299) == 0) bus.mute = ~bus.mute;
      step();
    end
    bus.l_valid = 1'b0;
    bus.r_valid = 1'b0;
    bus.mute    = 1'b0;

    // Reset in the right slot at bit_cnt 40, then restart from zero.
    for (int i = 0; i < 2 * FRAME_CLK && ((n / (2 * DIV)) % 64 != 40); i++) step();
    check("reached_bit40", 32'((n / (2 * DIV)) % 64), 32'd40);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    clear_counts();
    run(2 * FRAME_CLK);
    check("post_reset_frames", 32'(cnt_fs), 32'd2);
    check("post_reset_underruns", 32'(cnt_under), 32'd2);
    check("post_reset_overruns", 32'(cnt_over), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
    $finish;
  end

endmodule

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
- Output end of the audio path. Accepts the 24-bit left/right sample strobes produced by the front-end source mux (PCM or test data).
- Serializes the samples as a standard Philips I2S stream (64 bclk per frame, 32-bit slots, 24-bit MSB-first data) for the DAC.
- Generates bclk/lrclk from the master clock. Buffers one sample pair. Reports underrun and overrun.

Parameters:
- BCLK_DIV, 8, clk cycles per bclk half-period; must be >=1. Default gives 49.152 MHz / 16 = 3.072 MHz bclk, i.e. 48 kHz frames (1024 clk per frame).
- DATA_BITS, 24, sample width; fixed to 24 in this revision.
- SLOT_BITS, 32, bclk per channel slot; fixed to 32.

Ports:
- clk  in  1  master clock (mclk, 49.152 MHz)
- reset  in  1  synchronous, active-high reset
- l_valid  in  1  one-clk strobe, left sample present on l_data
- r_valid  in  1  one-clk strobe, right sample present on r_data
- l_data  in  24  left sample, two's complement
- r_data  in  24  right sample, two's complement
- mute  in  1  level; when high at frame start, zeros are loaded instead of held samples
- i2s_bclk  out  1  bit clock
- i2s_lrclk  out  1  word select: 0 = left slot, 1 = right slot
- i2s_sdata  out  1  serial data; changes on bclk falling edge
- frame_strobe  out  1  one-clk pulse at every frame start (bit_cnt wrap 63->0)
- underrun  out  1  one-clk pulse: frame started without a fresh L or R sample
- overrun  out  1  one-clk pulse: sample strobe arrived while the previous one was still unconsumed

Behaviour:
- Reset (synchronous, active-high):
  - Clears div_cnt, bclk, bit_cnt[5:0], both hold registers, both active words, l_fresh and r_fresh.
  - All outputs are 0 during reset and in the first cycle after reset.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1. At the terminal count it wraps to 0 and bclk toggles.
  - The first rising edge is at clk BCLK_DIV after reset release; the first falling edge is at 2*BCLK_DIV.
- Bit counter: on every cycle where bclk toggles 1->0, bit_cnt increments mod 64. i2s_lrclk, i2s_sdata and the frame logic update in that same cycle (registered, so they are visible one clk after the toggle decision, together with bclk low).
- Slot mapping:
  - lrclk = bit_cnt[5]; p = bit_cnt[4:0].
  - sdata = word[24-p] for p in 1..24, where word = active_l if bit_cnt[5]==0, else active_r.
  - sdata = 0 for p = 0 and for p = 25..31. This gives the I2S one-bclk delay; MSB appears at p=1.
- Frame start (falling-edge cycle where bit_cnt 63->0):
  - active_l and active_r load from hold_l and hold_r, or load 0 if mute=1.
  - frame_strobe pulses for one clk.
  - underrun pulses if l_fresh==0 or r_fresh==0. The previous hold value is repeated (hold registers unchanged).
  - l_fresh and r_fresh clear.
- Capture:
  - l_valid loads hold_l and sets l_fresh. r_valid does the same for the right channel independently.
  - If a strobe arrives while its fresh flag is already set and it is not the frame-start cycle, overrun pulses and the new sample overwrites the held one (newest wins).
- Simultaneous strobe and frame start:
  - active_l/r load the old hold value (pre-strobe).
  - The new sample lands in hold and fresh ends at 1, kept for the next frame.
  - No overrun is flagged.
- L and R are always loaded together at frame start, so channels never slip by a slot.
- mute does not affect hold/fresh/underrun/overrun. Its effect is visible from the next frame start only, never mid-frame.
- Reset mid-frame: the stream aborts immediately and outputs go low. The first post-reset frame transmits zeros.

Decomposition:
- Shared package audipus_audio_pkg holds:
  - SAMPLE_W=24, SLOT_W=32, BITS_PER_FRAME=64.
  - BCLK_DIV constants for 48k (8), 96k (4), 192k (2) at 49.152 MHz.
- One natural sub-module: i2s_clk_gen, containing div_cnt, bclk, bit_cnt, and single-cycle fall_tick/frame_tick outputs.
- Capture and serialize logic stays in the top.

Test Plan:
- BCLK_DIV=2, reset released, no strobes:
  - bclk period is 4 clk; lrclk toggles every 128 clk.
  - sdata stays 0.
  - frame_strobe fires every 256 clk.
  - underrun pulses on every frame.
- l_data=0xA5A5A5 and r_data=0x5A5A5A strobed once per frame, mid-frame:
  - Next frame's left slot shows 0, then the 24 bits of 0xA5A5A5 MSB-first on p=1..24, then 7 zeros.
  - Right slot shows 0x5A5A5A the same way.
  - No underrun or overrun.
- Two l_valid strobes in one frame (0x123456, then 0x7FFFFF):
  - overrun pulses once.
  - Next left slot carries 0x7FFFFF.
- l_valid/r_valid asserted exactly on the frame-start cycle with 0x800000:
  - Current frame sends the previous samples.
  - 0x800000 is sent in the following frame.
  - No overrun is flagged, and no underrun on that following frame.
- mute=1 with fresh samples 0x7FFF00:
  - Slots carry all zeros from the next frame start.
  - Deasserting mute restores 0x7FFF00 (repeated, with an underrun pulse) at the next frame start.
- reset asserted at bit_cnt=40:
  - All outputs are 0 the next clk.
  - After release, the first frame is all-zero data and timing restarts from div_cnt=0.
